// File: rtl/aes_key_expander.sv
// AES-128 key schedule: one round key per clock into an 11-entry register file, registered read port.
// Optional macro AES_KEYEXP_REVERSE_EN maps read index i to round key 10-i.
module aes_key_expander (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [0:127] key,
  output logic         busy,
  output logic         key_valid,
  input  logic [3:0]   rk_idx,
  output logic [0:127] round_key
);

  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[int'(x)*8 +: 8];
  endfunction

  function automatic logic [0:31] sub_word(input logic [0:31] w);
    return {sbox(w[0:7]), sbox(w[8:15]), sbox(w[16:23]), sbox(w[24:31])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  state_t       state;
  logic [3:0]   cnt;
  logic [7:0]   rcon;
  logic [0:127] cur_key;
  logic [0:127] rk [0:10];

  logic [0:31]  w3, temp, n0, n1, n2, n3;
  logic [0:127] next_key;
  logic [3:0]   eff_idx;
  logic         eff_ok;

  // Round function: SubWord(RotWord(w3)) ^ Rcon feeds the xor chain w0'..w3'
  assign w3       = cur_key[96:127];
  assign temp     = sub_word({w3[8:31], w3[0:7]}) ^ {rcon, 24'h000000};
  assign n0       = cur_key[0:31]  ^ temp;
  assign n1       = cur_key[32:63] ^ n0;
  assign n2       = cur_key[64:95] ^ n1;
  assign n3       = w3             ^ n2;
  assign next_key = {n0, n1, n2, n3};

`ifdef AES_KEYEXP_REVERSE_EN
  assign eff_idx = 4'd10 - rk_idx;
`else
  assign eff_idx = rk_idx;
`endif
  // Validity is judged on the raw index so 11..15 return zero in both modes
  assign eff_ok = (rk_idx <= 4'd10);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      key_valid <= 1'b0;
      cnt       <= 4'd0;
      rcon      <= 8'h00;
      cur_key   <= '0;
      round_key <= '0;
      for (int i = 0; i < 11; i++) rk[i] <= '0;
    end else begin
      round_key <= (key_valid && eff_ok) ? rk[eff_idx] : '0;
      case (state)
        IDLE, READY: begin
          if (start) begin
            rk[0]     <= key;
            cur_key   <= key;
            cnt       <= 4'd1;
            rcon      <= 8'h01;
            busy      <= 1'b1;
            key_valid <= 1'b0;
            state     <= EXPAND;
          end
        end
        EXPAND: begin
          rk[cnt] <= next_key;
          cur_key <= next_key;
          rcon    <= xtime(rcon);
          cnt     <= cnt + 4'd1;
          if (cnt == 4'd10) begin
            busy      <= 1'b0;
            key_valid <= 1'b1;
            state     <= READY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench for aes_key_expander using FIPS-197 and all-zero key vectors.
module tb_aes_key_expander;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [0:127] key;
  logic         busy;
  logic         key_valid;
  logic [3:0]   rk_idx;
  logic [0:127] round_key;

  int checks = 0;
  int passes = 0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK2 = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK1 = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK2 = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  aes_key_expander dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .key       (key),
    .busy      (busy),
    .key_valid (key_valid),
    .rk_idx    (rk_idx),
    .round_key (round_key)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Physical read index that addresses round key k in either build
  function automatic logic [3:0] phys(input int k);
`ifdef AES_KEYEXP_REVERSE_EN
    return 4'(10 - k);
`else
    return 4'(k);
`endif
  endfunction

  task automatic rd(input string tag, input int k, input logic [127:0] exp);
    rk_idx = phys(k);
    step();
    chk(tag, round_key, exp);
  endtask

  task automatic rd_raw(input string tag, input logic [3:0] idx, input logic [127:0] exp);
    rk_idx = idx;
    step();
    chk(tag, round_key, exp);
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    key    = '0;
    rk_idx = 4'd0;
    step();
    step();
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_valid", 128'(key_valid), 128'(0));
    chk("reset_rk", round_key, 128'h0);
    rst_n = 1'b1;
    step();

    // FIPS-197 key: key_valid exactly 10 edges after the start edge
    key   = FIPS_KEY;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t0_busy", 128'(busy), 128'(1));
    chk("t0_valid", 128'(key_valid), 128'(0));
    for (int i = 1; i < 10; i++) begin
      step();
      chk($sformatf("t%0d_valid", i), 128'(key_valid), 128'(0));
      chk($sformatf("t%0d_busy", i), 128'(busy), 128'(1));
    end
    step();
    chk("t10_valid", 128'(key_valid), 128'(1));
    chk("t10_busy", 128'(busy), 128'(0));
    rd("fips_rk1", 1, FIPS_RK1);
    rd("fips_rk2", 2, FIPS_RK2);
    rd("fips_rk10", 10, FIPS_RK10);
    rd("fips_rk0", 0, FIPS_KEY);
    rd_raw("fips_idx11", 4'd11, 128'h0);

    // Restart from READY with the zero key
    rk_idx = phys(1);
    key    = '0;
    start  = 1'b1;
    step();
    start = 1'b0;
    chk("rs_t0_valid", 128'(key_valid), 128'(0));
    chk("rs_t0_busy", 128'(busy), 128'(1));
    for (int i = 1; i < 10; i++) begin
      step();
      chk($sformatf("rs_t%0d_rk", i), round_key, 128'h0);
      chk($sformatf("rs_t%0d_valid", i), 128'(key_valid), 128'(0));
    end
    step();
    chk("rs_t10_valid", 128'(key_valid), 128'(1));
    rd("zero_rk1", 1, ZERO_RK1);
    rd("zero_rk2", 2, ZERO_RK2);
    rd("zero_rk10", 10, ZERO_RK10);
    rd("zero_rk0", 0, 128'h0);
    rd_raw("zero_idx12", 4'd12, 128'h0);
    rd_raw("zero_idx15", 4'd15, 128'h0);

    // Second start at T4 with a different key must be ignored
    key   = FIPS_KEY;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i < 4; i++) step();
    key   = {128{1'b1}};
    start = 1'b1;
    step();
    start = 1'b0;
    chk("ign_t4_busy", 128'(busy), 128'(1));
    for (int i = 5; i < 10; i++) step();
    chk("ign_t9_valid", 128'(key_valid), 128'(0));
    step();
    chk("ign_t10_valid", 128'(key_valid), 128'(1));
    rd("ign_rk10", 10, FIPS_RK10);
    rd("ign_rk1", 1, FIPS_RK1);
    rd("ign_rk0", 0, FIPS_KEY);

    // Asynchronous reset in the middle of an expansion
    rk_idx = phys(0);
    key    = '0;
    start  = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i < 5; i++) step();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 128'(busy), 128'(0));
    chk("arst_valid", 128'(key_valid), 128'(0));
    chk("arst_rk", round_key, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) step();
    chk("idle_busy", 128'(busy), 128'(0));
    chk("idle_valid", 128'(key_valid), 128'(0));
    rd("idle_rk0", 0, 128'h0);

    // Recovery with a fresh start after the abort
    key   = FIPS_KEY;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i <= 10; i++) step();
    chk("rec_valid", 128'(key_valid), 128'(1));
    rd("rec_rk10", 10, FIPS_RK10);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
